color_game_ctrl: RTL and testbench

- Round sequencer for the motion game. It sits downstream of the 4-way corner color detector and consumes its per-frame pass_LT/RT/LB/RB flags.
- Each round: pick a random target corner, show it, wait for the player to hold the correct color in that corner for a number of consecutive frames, then score a hit or charge a miss/timeout.
- Drives target/result/score/lives outputs to the VGA overlay and the score display.

---
 rtl/color_game_pkg.sv | 26 ++
 rtl/color_game_ctrl_if.sv | 31 +++
 rtl/frame_tick_gen.sv | 18 +
 rtl/color_game_ctrl.sv | 147 ++++++++++++++
 tb/tb_color_game_ctrl.sv | 335 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/color_game_pkg.sv
// Shared types and helpers for the motion-game round sequencer.
// State encodings follow the game_state_t order so debug dumps decode directly.
package color_game_pkg;

   typedef enum logic [2:0] {IDLE, SHOW, WAIT, RESULT, GAME_OVER} game_state_t;
   typedef enum logic [1:0] {LT, RT, LB, RB} corner_t;

   localparam logic [2:0] ST_IDLE      = IDLE;
   localparam logic [2:0] ST_SHOW      = SHOW;
   localparam logic [2:0] ST_WAIT      = WAIT;
   localparam logic [2:0] ST_RESULT    = RESULT;
   localparam logic [2:0] ST_GAME_OVER = GAME_OVER;

   // Fibonacci taps 8,6,5,4 expressed as a mask over lfsr[7:0]
   localparam logic [7:0] LFSR_TAPS = 8'hB8;

   function automatic logic [7:0] lfsr_step(input logic [7:0] cur);
      return {cur[6:0], ^(cur & LFSR_TAPS)};
   endfunction

   // Nudges a repeated candidate to the next corner so consecutive targets differ
   function automatic logic [1:0] pick_target(input logic [1:0] cand, input logic [1:0] prev);
      return (cand == prev) ? cand + 2'd1 : cand;
   endfunction

endpackage

// File: rtl/color_game_ctrl_if.sv
// Player-facing bundle of the round sequencer: detector flags and start in,
// overlay/score-display signals out.
interface color_game_ctrl_if;

   logic       start;
   logic       pass_LT;
   logic       pass_RT;
   logic       pass_LB;
   logic       pass_RB;
   logic [1:0] target;
   logic       target_show;
   logic       result_hit;
   logic       result_miss;
   logic [7:0] score;
   logic [2:0] lives;
   logic       game_over;
   logic [2:0] state;

   modport slave (
      input  start, pass_LT, pass_RT, pass_LB, pass_RB,
      output target, target_show, result_hit, result_miss,
             score, lives, game_over, state
   );

   modport master (
      output start, pass_LT, pass_RT, pass_LB, pass_RB,
      input  target, target_show, result_hit, result_miss,
             score, lives, game_over, state
   );

endinterface

// File: rtl/frame_tick_gen.sv
// One-cycle pulse on each rising vsync edge; shared with the VGA overlay.
module frame_tick_gen (
   input  logic clk,
   input  logic rst_n,
   input  logic vsync,
   output logic frame_tick
);

   logic vs_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) vs_d <= 1'b0;
      else        vs_d <= vsync;
   end

   assign frame_tick = vsync & ~vs_d;

endmodule

// File: rtl/color_game_ctrl.sv
// Round sequencer: shows a random corner, waits for the player's colour there,
// then scores a hit or charges a miss until lives run out.
module color_game_ctrl
   import color_game_pkg::*;
#(
   parameter int         SHOW_FRAMES    = 30,
   parameter int         TIMEOUT_FRAMES = 180,
   parameter int         HIT_FRAMES     = 3,
   parameter int         RESULT_FRAMES  = 60,
   parameter int         LIVES          = 3,
   parameter logic [7:0] LFSR_SEED      = 8'hA5
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               vsync,
   color_game_ctrl_if.slave   gif
);

   localparam int MAX_SR     = (SHOW_FRAMES > RESULT_FRAMES) ? SHOW_FRAMES : RESULT_FRAMES;
   localparam int MAX_FRAMES = (MAX_SR > TIMEOUT_FRAMES) ? MAX_SR : TIMEOUT_FRAMES;
   localparam int CNT_W      = $clog2(MAX_FRAMES) + 1;
   localparam int HIT_W      = $clog2(HIT_FRAMES) + 1;

   localparam logic [CNT_W-1:0] SHOW_LAST    = CNT_W'(SHOW_FRAMES - 1);
   localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_FRAMES - 1);
   localparam logic [CNT_W-1:0] RESULT_LAST  = CNT_W'(RESULT_FRAMES - 1);
   localparam logic [HIT_W-1:0] HIT_NEEDED   = HIT_W'(HIT_FRAMES);
   localparam logic [2:0]       LIVES_INIT   = 3'(LIVES);

   logic             frame_tick;
   logic [7:0]       lfsr;
   logic [2:0]       state_q;
   logic [1:0]       target_q;
   logic             last_hit;
   logic [7:0]       score_q;
   logic [2:0]       lives_q;
   logic [CNT_W-1:0] frame_cnt;
   logic [HIT_W-1:0] hit_cnt;
   logic [3:0]       pass_vec;
   logic             target_flag;
   logic [HIT_W-1:0] hit_next;

   frame_tick_gen u_frame_tick (
      .clk        (clk),
      .rst_n      (rst_n),
      .vsync      (vsync),
      .frame_tick (frame_tick)
   );

   assign pass_vec    = {gif.pass_RB, gif.pass_LB, gif.pass_RT, gif.pass_LT};
   assign target_flag = pass_vec[target_q];
   assign hit_next    = hit_cnt + 1'b1;

   // Free-running so the pick depends on how long the player took
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) lfsr <= LFSR_SEED;
      else        lfsr <= lfsr_step(lfsr);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         target_q  <= 2'd0;
         last_hit  <= 1'b0;
         score_q   <= 8'd0;
         lives_q   <= LIVES_INIT;
         frame_cnt <= '0;
         hit_cnt   <= '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (gif.start) begin
                  state_q   <= ST_SHOW;
                  score_q   <= 8'd0;
                  lives_q   <= LIVES_INIT;
                  target_q  <= lfsr[1:0];
                  frame_cnt <= '0;
               end
            end

            ST_SHOW: begin
               if (frame_tick) begin
                  if (frame_cnt == SHOW_LAST) begin
                     state_q   <= ST_WAIT;
                     frame_cnt <= '0;
                     hit_cnt   <= '0;
                  end else begin
                     frame_cnt <= frame_cnt + 1'b1;
                  end
               end
            end

            // A hit completing on the timeout tick still counts as a hit
            ST_WAIT: begin
               if (frame_tick) begin
                  hit_cnt <= target_flag ? hit_next : '0;
                  if (target_flag && (hit_next == HIT_NEEDED)) begin
                     state_q   <= ST_RESULT;
                     last_hit  <= 1'b1;
                     frame_cnt <= '0;
                     if (score_q != 8'hFF) score_q <= score_q + 8'd1;
                  end else if (frame_cnt == TIMEOUT_LAST) begin
                     state_q   <= ST_RESULT;
                     last_hit  <= 1'b0;
                     frame_cnt <= '0;
                     if (lives_q != 3'd0) lives_q <= lives_q - 3'd1;
                  end else begin
                     frame_cnt <= frame_cnt + 1'b1;
                  end
               end
            end

            ST_RESULT: begin
               if (frame_tick) begin
                  if (frame_cnt == RESULT_LAST) begin
                     frame_cnt <= '0;
                     if (lives_q == 3'd0) begin
                        state_q <= ST_GAME_OVER;
                     end else begin
                        state_q  <= ST_SHOW;
                        target_q <= pick_target(lfsr[1:0], target_q);
                     end
                  end else begin
                     frame_cnt <= frame_cnt + 1'b1;
                  end
               end
            end

            ST_GAME_OVER: begin
               if (gif.start) state_q <= ST_IDLE;
            end

            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign gif.target      = target_q;
   assign gif.target_show = (state_q == ST_SHOW) || (state_q == ST_WAIT);
   assign gif.result_hit  = (state_q == ST_RESULT) && last_hit;
   assign gif.result_miss = (state_q == ST_RESULT) && !last_hit;
   assign gif.score       = score_q;
   assign gif.lives       = lives_q;
   assign gif.game_over   = (state_q == ST_GAME_OVER);
   assign gif.state       = state_q;

endmodule

// File: tb/tb_color_game_ctrl.sv
// Scenario bench for color_game_ctrl with default parameters; a frame is one
// vsync pulse every four clocks and expectations come from the game rules.
module tb_color_game_ctrl;

   localparam logic [2:0] S_IDLE = 3'd0, S_SHOW = 3'd1, S_WAIT = 3'd2,
                          S_RESULT = 3'd3, S_OVER = 3'd4;

   logic clk = 1'b0;
   logic rst_n;
   logic vsync;

   color_game_ctrl_if gif ();

   color_game_ctrl dut (
      .clk   (clk),
      .rst_n (rst_n),
      .vsync (vsync),
      .gif   (gif)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   logic [7:0] m_lfsr, m_prev;
   logic [1:0] tick_cand;
   logic [1:0] m_target;
   int         m_score, m_lives;

   function automatic logic [7:0] lfsr_adv(input logic [7:0] v);
      return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
   endfunction

   function automatic logic [1:0] pick(input logic [1:0] cand, input logic [1:0] prev);
      return (cand == prev) ? cand + 2'd1 : cand;
   endfunction

   function automatic logic [3:0] onehot(input logic [1:0] c);
      logic [3:0] v;
      v = 4'b0001;
      return v << c;
   endfunction

   // Reference LFSR; m_prev is the value the DUT saw just before the latest edge
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_lfsr <= 8'hA5;
         m_prev <= 8'hA5;
      end else begin
         m_prev <= m_lfsr;
         m_lfsr <= lfsr_adv(m_lfsr);
      end
   end

   task automatic do_frame(input logic [3:0] p);
      @(negedge clk);
      {gif.pass_RB, gif.pass_LB, gif.pass_RT, gif.pass_LT} = p;
      vsync = 1'b1;
      @(negedge clk);
      vsync = 1'b0;
      tick_cand = m_prev[1:0];
      @(negedge clk);
      @(negedge clk);
   endtask

   task automatic run_frames(input int n, input logic [3:0] p);
      for (int i = 0; i < n; i++) do_frame(p);
   endtask

   task automatic pass_result(input int n);
      for (int i = 0; i < n; i++) do_frame(4'($urandom));
      if (m_lives != 0) m_target = pick(tick_cand, m_target);
   endtask

   task automatic start_from_idle();
      @(negedge clk);
      gif.start = 1'b1;
      @(negedge clk);
      gif.start = 1'b0;
      m_target = m_prev[1:0];
      m_score  = 0;
      m_lives  = 3;
   endtask

   task automatic restart_from_over(output logic [2:0] mid_state);
      @(negedge clk);
      gif.start = 1'b1;
      @(negedge clk);
      mid_state = gif.state;
      @(negedge clk);
      gif.start = 1'b0;
      m_target = m_prev[1:0];
      m_score  = 0;
      m_lives  = 3;
   endtask

   task automatic test_reset();
      logic [20:0] got;
      rst_n = 1'b1; vsync = 1'b0; gif.start = 1'b0;
      {gif.pass_RB, gif.pass_LB, gif.pass_RT, gif.pass_LT} = 4'd0;
      #1 rst_n = 1'b0;
      #11;
      got = {gif.state, gif.target, gif.target_show, gif.result_hit, gif.result_miss,
             gif.score, gif.lives, gif.game_over};
      checks++;
      if (got !== {3'd0, 2'd0, 1'b0, 1'b0, 1'b0, 8'd0, 3'd3, 1'b0}) begin
         errors++; $display("[TB] FAIL reset_outputs got %h expected %h", got, {3'd0, 2'd0, 3'b0, 8'd0, 3'd3, 1'b0});
      end
      checks++;
      if (dut.lfsr !== 8'hA5) begin errors++; $display("[TB] FAIL reset_lfsr got %h expected a5", dut.lfsr); end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_timeout_round();
      logic [1:0] first;
      start_from_idle();
      checks++;
      if (gif.state !== S_SHOW || gif.target !== m_target || gif.target_show !== 1'b1) begin
         errors++; $display("[TB] FAIL first_pick state %0d target %0d expected state %0d target %0d", gif.state, gif.target, S_SHOW, m_target);
      end
      run_frames(29, 4'd0);
      checks++;
      if (gif.state !== S_SHOW) begin errors++; $display("[TB] FAIL show_29 got %0d expected %0d", gif.state, S_SHOW); end
      do_frame(4'd0);
      checks++;
      if (gif.state !== S_WAIT) begin errors++; $display("[TB] FAIL show_to_wait got %0d expected %0d", gif.state, S_WAIT); end
      run_frames(179, 4'd0);
      checks++;
      if (gif.state !== S_WAIT) begin errors++; $display("[TB] FAIL wait_179 got %0d expected %0d", gif.state, S_WAIT); end
      do_frame(4'd0);
      m_lives = 2;
      checks++;
      if (gif.state !== S_RESULT || gif.result_miss !== 1'b1 || gif.result_hit !== 1'b0 || gif.lives !== 3'(m_lives)) begin
         errors++; $display("[TB] FAIL timeout_miss state %0d miss %0b lives %0d expected %0d 1 %0d", gif.state, gif.result_miss, gif.lives, S_RESULT, m_lives);
      end
      run_frames(59, 4'd0);
      checks++;
      if (gif.result_miss !== 1'b1) begin errors++; $display("[TB] FAIL result_hold got %0b expected 1", gif.result_miss); end
      first = m_target;
      pass_result(1);
      checks++;
      if (gif.state !== S_SHOW || gif.target !== m_target || gif.target === first || gif.result_miss !== 1'b0) begin
         errors++; $display("[TB] FAIL second_pick state %0d target %0d expected %0d %0d (prev %0d)", gif.state, gif.target, S_SHOW, m_target, first);
      end
   endtask

   task automatic test_hit();
      run_frames(30, 4'd0);
      do_frame(onehot(m_target));
      do_frame(onehot(m_target));
      checks++;
      if (gif.state !== S_WAIT) begin errors++; $display("[TB] FAIL hit_two_ticks got %0d expected %0d", gif.state, S_WAIT); end
      do_frame(onehot(m_target));
      m_score++;
      checks++;
      if (gif.result_hit !== 1'b1 || gif.score !== 8'(m_score)) begin
         errors++; $display("[TB] FAIL hit_third_tick hit %0b score %0d expected 1 %0d", gif.result_hit, gif.score, m_score);
      end
      pass_result(60);
      checks++;
      if (gif.state !== S_SHOW || gif.target !== m_target) begin
         errors++; $display("[TB] FAIL hit_next_pick state %0d target %0d expected %0d %0d", gif.state, gif.target, S_SHOW, m_target);
      end
      run_frames(30, 4'd0);
      do_frame(onehot(m_target));
      do_frame(onehot(m_target));
      do_frame(4'd0);
      do_frame(onehot(m_target));
      do_frame(onehot(m_target));
      checks++;
      if (gif.state !== S_WAIT) begin errors++; $display("[TB] FAIL gap_resets_run got %0d expected %0d", gif.state, S_WAIT); end
      do_frame(onehot(m_target));
      m_score++;
      checks++;
      if (gif.result_hit !== 1'b1 || gif.score !== 8'(m_score)) begin
         errors++; $display("[TB] FAIL hit_after_gap hit %0b score %0d expected 1 %0d", gif.result_hit, gif.score, m_score);
      end
      pass_result(60);
   endtask

   task automatic test_nontarget();
      run_frames(30, 4'd0);
      @(negedge clk) gif.start = 1'b1;
      @(negedge clk) gif.start = 1'b0;
      checks++;
      if (gif.state !== S_WAIT) begin errors++; $display("[TB] FAIL start_ignored got %0d expected %0d", gif.state, S_WAIT); end
      run_frames(180, ~onehot(m_target));
      m_lives--;
      checks++;
      if (gif.result_miss !== 1'b1 || gif.score !== 8'(m_score) || gif.lives !== 3'(m_lives)) begin
         errors++; $display("[TB] FAIL nontarget_miss miss %0b score %0d lives %0d expected 1 %0d %0d", gif.result_miss, gif.score, gif.lives, m_score, m_lives);
      end
      run_frames(20, ~onehot(m_target));
      pass_result(40);
   endtask

   task automatic test_boundary_hit();
      run_frames(30, 4'd0);
      run_frames(177, 4'd0);
      do_frame(onehot(m_target));
      do_frame(onehot(m_target));
      checks++;
      if (gif.state !== S_WAIT) begin errors++; $display("[TB] FAIL boundary_pre got %0d expected %0d", gif.state, S_WAIT); end
      do_frame(onehot(m_target));
      m_score++;
      checks++;
      if (gif.result_hit !== 1'b1 || gif.result_miss !== 1'b0 || gif.lives !== 3'(m_lives) || gif.score !== 8'(m_score)) begin
         errors++; $display("[TB] FAIL boundary_hit hit %0b lives %0d score %0d expected 1 %0d %0d", gif.result_hit, gif.lives, gif.score, m_lives, m_score);
      end
      pass_result(60);
   endtask

   task automatic test_game_over();
      logic [2:0] mid;
      run_frames(210, 4'd0);
      m_lives--;
      pass_result(60);
      checks++;
      if (gif.state !== S_OVER || gif.game_over !== 1'b1 || gif.score !== 8'(m_score) || gif.target_show !== 1'b0) begin
         errors++; $display("[TB] FAIL game_over state %0d go %0b score %0d expected %0d 1 %0d", gif.state, gif.game_over, gif.score, S_OVER, m_score);
      end
      run_frames(3, 4'hF);
      checks++;
      if (gif.state !== S_OVER) begin errors++; $display("[TB] FAIL over_holds got %0d expected %0d", gif.state, S_OVER); end
      restart_from_over(mid);
      checks++;
      if (mid !== S_IDLE || gif.state !== S_SHOW || gif.lives !== 3'd3 || gif.score !== 8'd0 || gif.target !== m_target) begin
         errors++; $display("[TB] FAIL restart mid %0d state %0d lives %0d score %0d target %0d expected %0d %0d 3 0 %0d", mid, gif.state, gif.lives, gif.score, gif.target, S_IDLE, S_SHOW, m_target);
      end
      for (int i = 0; i < 3; i++) begin
         run_frames(210, 4'd0);
         m_lives--;
         checks++;
         if (gif.result_miss !== 1'b1 || gif.lives !== 3'(m_lives)) begin
            errors++; $display("[TB] FAIL three_timeouts miss %0b lives %0d expected 1 %0d", gif.result_miss, gif.lives, m_lives);
         end
         pass_result(60);
      end
      checks++;
      if (gif.state !== S_OVER || gif.game_over !== 1'b1 || gif.score !== 8'd0) begin
         errors++; $display("[TB] FAIL second_game_over state %0d go %0b score %0d expected %0d 1 0", gif.state, gif.game_over, gif.score, S_OVER);
      end
   endtask

   task automatic test_random();
      logic [2:0] mid;
      logic [3:0] p;
      int         prob, run, outcome;
      restart_from_over(mid);
      for (int r = 0; r < 6 && m_lives > 0; r++) begin
         for (int f = 0; f < 30; f++) do_frame(4'($urandom));
         checks++;
         if (gif.state !== S_WAIT || gif.target !== m_target) begin
            errors++; $display("[TB] FAIL rand_enter_wait state %0d target %0d expected %0d %0d", gif.state, gif.target, S_WAIT, m_target);
         end
         case ($urandom_range(2))
            0:       prob = 0;
            1:       prob = 35;
            default: prob = 80;
         endcase
         run = 0;
         outcome = 0;
         for (int f = 1; f <= 180 && outcome == 0; f++) begin
            p = 4'($urandom) & ~onehot(m_target);
            if ($urandom_range(99) < prob) p = p | onehot(m_target);
            do_frame(p);
            run = p[m_target] ? run + 1 : 0;
            if (run == 3)       outcome = 1;
            else if (f == 180)  outcome = 2;
            checks++;
            if (gif.state !== ((outcome != 0) ? S_RESULT : S_WAIT)) begin
               errors++; $display("[TB] FAIL rand_wait_step r%0d f%0d got %0d outcome %0d", r, f, gif.state, outcome);
            end
         end
         if (outcome == 1) m_score++;
         else              m_lives--;
         checks++;
         if (gif.result_hit !== (outcome == 1) || gif.result_miss !== (outcome == 2) ||
             gif.score !== 8'(m_score) || gif.lives !== 3'(m_lives)) begin
            errors++; $display("[TB] FAIL rand_result hit %0b miss %0b score %0d lives %0d expected outcome %0d score %0d lives %0d", gif.result_hit, gif.result_miss, gif.score, gif.lives, outcome, m_score, m_lives);
         end
         pass_result(60);
         checks++;
         if (gif.state !== ((m_lives == 0) ? S_OVER : S_SHOW) || (m_lives != 0 && gif.target !== m_target)) begin
            errors++; $display("[TB] FAIL rand_next state %0d target %0d expected lives %0d target %0d", gif.state, gif.target, m_lives, m_target);
         end
      end
   endtask

   task automatic test_reset_mid();
      logic [20:0] got;
      @(negedge clk) rst_n = 1'b0;
      @(negedge clk) rst_n = 1'b1;
      start_from_idle();
      for (int i = 0; i < 5; i++) begin
         run_frames(30, 4'd0);
         run_frames(3, onehot(m_target));
         m_score++;
         pass_result(60);
      end
      run_frames(40, 4'd0);
      checks++;
      if (gif.state !== S_WAIT || gif.score !== 8'd5) begin
         errors++; $display("[TB] FAIL pre_reset state %0d score %0d expected %0d 5", gif.state, gif.score, S_WAIT);
      end
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      got = {gif.state, gif.target, gif.target_show, gif.result_hit, gif.result_miss,
             gif.score, gif.lives, gif.game_over};
      checks++;
      if (got !== {3'd0, 2'd0, 1'b0, 1'b0, 1'b0, 8'd0, 3'd3, 1'b0}) begin
         errors++; $display("[TB] FAIL async_reset got %h expected %h", got, {3'd0, 2'd0, 3'b0, 8'd0, 3'd3, 1'b0});
      end
      checks++;
      if (dut.lfsr !== 8'hA5) begin errors++; $display("[TB] FAIL async_reset_lfsr got %h expected a5", dut.lfsr); end
      @(negedge clk) rst_n = 1'b1;
   endtask

   initial begin
      test_reset();
      test_timeout_round();
      test_hit();
      test_nontarget();
      test_boundary_hit();
      test_game_over();
      test_random();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
